// File: rtl/bomb_sequencer.sv
// bomb_sequencer: sequences the game bomb's two-digit BCD countdown.
// Arms and loads the countdown, decrements it once per one_sec tick and
// drives the warning, defuse and explosion outputs. The countdown digits
// live here so the display can read them directly.
//
// Optional feature macro: BOMB_SEQUENCER_PAUSE_EN
//   defined   -> adds the 'pause' toggle input and the PAUSED state (5)
//   undefined -> no pause port; encoding 5 is unreachable and recovers to IDLE
//
// Input events (arm, defuse, one_sec, pause) are single-cycle pulses
// sampled on the rising clock edge; there is no backpressure. Every output
// is a register or a direct copy of one, so no input reaches an output
// without passing through a flop.
module bomb_sequencer #(
  parameter int START_SEC     = 30,
  parameter int WARN_SEC      = 5,
  parameter int EXPLODE_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm,
  input  logic       defuse,
  input  logic       one_sec,
`ifdef BOMB_SEQUENCER_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic [2:0] state_out,
  output logic       bomb_active,
  output logic       warn,
  output logic       explode,
  output logic       defused
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COUNT   = 3'd2,
    S_EXPLODE = 3'd3,
    S_DEFUSED = 3'd4,
    S_PAUSED  = 3'd5
  } state_t;

  localparam logic [3:0] START_TENS = 4'(START_SEC / 10);
  localparam logic [3:0] START_ONES = 4'(START_SEC % 10);
  localparam logic [6:0] WARN_VAL   = 7'(WARN_SEC);
  localparam logic [3:0] LAST_TICK  = 4'(EXPLODE_TICKS - 1);

  state_t     state;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] tick_cnt;

  state_t     nxt_state;
  logic [3:0] nxt_tens;
  logic [3:0] nxt_ones;
  logic [3:0] nxt_cnt;
  logic [6:0] nxt_value;
  logic       nxt_active;

  // Next-state, next-digit and explode-tick-counter logic.
  always_comb begin
    nxt_state = state;
    nxt_tens  = tens;
    nxt_ones  = ones;
    nxt_cnt   = tick_cnt;
    case (state)
      S_IDLE: begin
        if (arm) nxt_state = S_LOAD;
      end
      S_LOAD: begin
        nxt_tens  = START_TENS;
        nxt_ones  = START_ONES;
        nxt_state = S_COUNT;
      end
      S_COUNT: begin
        if (defuse) begin
          // Defuse wins even over the final tick; digits freeze.
          nxt_state = S_DEFUSED;
`ifdef BOMB_SEQUENCER_PAUSE_EN
        end else if (pause) begin
          nxt_state = S_PAUSED;
`endif
        end else if (one_sec) begin
          if (tens == 4'd0 && ones <= 4'd1) begin
            // Last second gone: show 00 and blow up on the same edge.
            nxt_tens  = 4'd0;
            nxt_ones  = 4'd0;
            nxt_cnt   = 4'd0;
            nxt_state = S_EXPLODE;
          end else if (ones == 4'd0) begin
            nxt_ones = 4'd9;
            nxt_tens = tens - 4'd1;
          end else begin
            nxt_ones = ones - 4'd1;
          end
        end
      end
      S_EXPLODE: begin
        nxt_tens = 4'd0;
        nxt_ones = 4'd0;
        if (one_sec) begin
          if (tick_cnt >= LAST_TICK) begin
            nxt_cnt   = 4'd0;
            nxt_state = S_IDLE;
          end else begin
            nxt_cnt = tick_cnt + 4'd1;
          end
        end
      end
      S_DEFUSED: begin
        if (arm) nxt_state = S_LOAD;
      end
`ifdef BOMB_SEQUENCER_PAUSE_EN
      S_PAUSED: begin
        if (defuse)     nxt_state = S_DEFUSED;
        else if (pause) nxt_state = S_COUNT;
      end
`endif
      default: begin
        // Unused encodings fall back to a clean idle.
        nxt_state = S_IDLE;
        nxt_tens  = 4'd0;
        nxt_ones  = 4'd0;
        nxt_cnt   = 4'd0;
      end
    endcase
  end

  // Binary value of the next digits, used to register warn.
  assign nxt_value = 7'(nxt_tens) * 7'd10 + 7'(nxt_ones);

  // Bomb counts as active while the countdown is live (running or paused).
`ifdef BOMB_SEQUENCER_PAUSE_EN
  assign nxt_active = (nxt_state == S_COUNT) || (nxt_state == S_PAUSED);
`else
  assign nxt_active = (nxt_state == S_COUNT);
`endif

  // State, digits, counter and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tens        <= 4'd0;
      ones        <= 4'd0;
      tick_cnt    <= 4'd0;
      bomb_active <= 1'b0;
      warn        <= 1'b0;
      explode     <= 1'b0;
      defused     <= 1'b0;
    end else begin
      state       <= nxt_state;
      tens        <= nxt_tens;
      ones        <= nxt_ones;
      tick_cnt    <= nxt_cnt;
      bomb_active <= nxt_active;
      warn        <= nxt_active && (nxt_value <= WARN_VAL);
      explode     <= (nxt_state == S_EXPLODE);
      defused     <= (nxt_state == S_DEFUSED);
    end
  end

  assign digit_tens = tens;
  assign digit_ones = ones;
  assign state_out  = state;

endmodule
